// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demultiplexer with per-output FIFOs.
// Beats are routed by select; each output has its own back-pressure.
module demux12_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [7:0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [7:0]       beat_q, beat_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = valid_q;
  assign data_o  = out_q;
  assign count_o = beat_q;

  // A full FIFO refuses a push even when it pops this cycle.
  assign push = push_i & ~full_o;
  assign pop  = valid_q & ready_i;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d   = rd_q + 1'b1;
      beat_d = beat_q + 8'd1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
    // Output register tracks the head and holds when empty.
    out_d   = valid_d ? mem_d[rd_d] : out_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end
endmodule

module demux12_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic             in_valid,
  input  logic             select,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [7:0]       count1,
  output logic [7:0]       count2
);
  logic full1, full2;
  logic push1, push2;

  assign in_ready = select ? ~full2 : ~full1;
  assign push1    = in_valid & ~select;
  assign push2    = in_valid & select;

  demux12_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push1),
    .data_i  (input1),
    .ready_i (out1_ready),
    .full_o  (full1),
    .valid_o (out1_valid),
    .data_o  (out1),
    .count_o (count1)
  );

  demux12_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push2),
    .data_i  (input1),
    .ready_i (out2_ready),
    .full_o  (full2),
    .valid_o (out2_valid),
    .data_o  (out2),
    .count_o (count2)
  );
endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: directed table,
// corner sequences and random traffic against a queue model.
module tb_demux12_stream;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, select, in_ready;
  logic [7:0] input1, out1, out2, count1, count2;
  logic       out1_valid, out2_valid, out1_ready, out2_ready;

  always #5 clk = ~clk;

  demux12_stream #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .input1(input1), .in_valid(in_valid),
    .select(select), .in_ready(in_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2(out2), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .count1(count1), .count2(count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] last1 = 8'h00, last2 = 8'h00;
  logic [7:0] m_c1 = 8'h00, m_c2 = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [7:0] d, input logic a, input logic b,
                      output logic rdy_s);
    bit acc, p1, p2;
    rst = r; in_valid = v; select = s; input1 = d;
    out1_ready = a; out2_ready = b;
    #1;
    rdy_s = in_ready;
    if (!r) chk("in_ready", int'(in_ready),
                int'(s ? (q2.size() < DEPTH) : (q1.size() < DEPTH)));
    @(posedge clk);
    if (r) begin
      q1.delete(); q2.delete();
      last1 = 0; last2 = 0; m_c1 = 0; m_c2 = 0;
    end else begin
      acc = v && (s ? (q2.size() < DEPTH) : (q1.size() < DEPTH));
      p1 = a && (q1.size() > 0);
      p2 = b && (q2.size() > 0);
      if (p1) begin void'(q1.pop_front()); m_c1++; end
      if (p2) begin void'(q2.pop_front()); m_c2++; end
      if (acc) begin
        if (s) q2.push_back(d);
        else   q1.push_back(d);
      end
      if (q1.size() > 0) last1 = q1[0];
      if (q2.size() > 0) last2 = q2[0];
    end
    @(negedge clk);
    chk("out1_valid", int'(out1_valid), int'(q1.size() > 0));
    chk("out2_valid", int'(out2_valid), int'(q2.size() > 0));
    chk("out1", int'(out1), int'(last1));
    chk("out2", int'(out2), int'(last2));
    chk("count1", int'(count1), int'(m_c1));
    chk("count2", int'(count2), int'(m_c2));
  endtask

  typedef struct {
    logic v, s;
    logic [7:0] d;
    logic a, b, rdy, v1;
    logic [7:0] o1;
    logic v2;
    logic [7:0] o2, c1, c2;
  } vec_t;

  vec_t tbl[11];
  logic rs;

  initial begin
    rst = 1; in_valid = 0; select = 0; input1 = 0;
    out1_ready = 0; out2_ready = 0;

    // v s d a b | rdy v1 o1 v2 o2 c1 c2
    tbl[0]  = '{1,0,8'h11,1,1, 1, 1,8'h11, 0,8'h00, 8'd0,8'd0};
    tbl[1]  = '{1,1,8'h22,1,1, 1, 0,8'h11, 1,8'h22, 8'd1,8'd0};
    tbl[2]  = '{0,0,8'h00,1,1, 1, 0,8'h11, 0,8'h22, 8'd1,8'd1};
    tbl[3]  = '{1,0,8'hA0,0,0, 1, 1,8'hA0, 0,8'h22, 8'd1,8'd1};
    tbl[4]  = '{1,0,8'hA1,0,0, 1, 1,8'hA0, 0,8'h22, 8'd1,8'd1};
    tbl[5]  = '{1,0,8'hA2,0,0, 0, 1,8'hA0, 0,8'h22, 8'd1,8'd1};
    tbl[6]  = '{1,1,8'hB0,0,0, 1, 1,8'hA0, 1,8'hB0, 8'd1,8'd1};
    tbl[7]  = '{1,0,8'hA2,1,0, 0, 1,8'hA1, 1,8'hB0, 8'd2,8'd1};
    tbl[8]  = '{1,0,8'hA2,0,0, 1, 1,8'hA1, 1,8'hB0, 8'd2,8'd1};
    tbl[9]  = '{0,0,8'h00,1,1, 0, 1,8'hA2, 0,8'hB0, 8'd3,8'd2};
    tbl[10] = '{0,0,8'h00,1,1, 1, 0,8'hA2, 0,8'hB0, 8'd4,8'd2};

    step(1,0,0,0,0,0,rs);
    step(1,0,0,0,0,0,rs);
    chk("rst_v1", int'(out1_valid), 0);
    chk("rst_v2", int'(out2_valid), 0);
    chk("rst_c1", int'(count1), 0);
    chk("rst_c2", int'(count2), 0);
    chk("rst_o1", int'(out1), 0);
    rst = 0; in_valid = 0; select = 0; #1;
    chk("rst_rdy0", int'(in_ready), 1);
    select = 1; #1;
    chk("rst_rdy1", int'(in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a, tbl[i].b, rs);
      chk($sformatf("tbl%0d_rdy", i), int'(rs), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_v1", i), int'(out1_valid), int'(tbl[i].v1));
      chk($sformatf("tbl%0d_o1", i), int'(out1), int'(tbl[i].o1));
      chk($sformatf("tbl%0d_v2", i), int'(out2_valid), int'(tbl[i].v2));
      chk($sformatf("tbl%0d_o2", i), int'(out2), int'(tbl[i].o2));
      chk($sformatf("tbl%0d_c1", i), int'(count1), int'(tbl[i].c1));
      chk($sformatf("tbl%0d_c2", i), int'(count2), int'(tbl[i].c2));
    end

    // Concurrent push/pop stream
    step(1,0,0,0,0,0,rs);
    for (int i = 0; i < 16; i++) begin
      step(0,1,0,8'(i),1,0,rs);
      chk("stream_rdy", int'(rs), 1);
      chk("stream_v1", int'(out1_valid), 1);
      chk("stream_o1", int'(out1), i);
    end
    step(0,0,0,0,1,0,rs);
    chk("stream_c1", int'(count1), 16);
    chk("stream_empty", int'(out1_valid), 0);

    // Reset with beats buffered on both sides
    step(0,1,0,8'h31,0,0,rs);
    step(0,1,0,8'h32,0,0,rs);
    step(0,1,1,8'h41,0,0,rs);
    step(0,1,1,8'h42,0,0,rs);
    chk("pre_rst_v1", int'(out1_valid), 1);
    chk("pre_rst_v2", int'(out2_valid), 1);
    step(1,0,0,0,1,1,rs);
    chk("mid_rst_v1", int'(out1_valid), 0);
    chk("mid_rst_v2", int'(out2_valid), 0);
    chk("mid_rst_c1", int'(count1), 0);
    chk("mid_rst_c2", int'(count2), 0);
    for (int i = 0; i < 4; i++) begin
      step(0,0,0,0,1,1,rs);
      chk("post_rst_v1", int'(out1_valid), 0);
      chk("post_rst_v2", int'(out2_valid), 0);
    end

    // Counter wrap on out2
    step(1,0,0,0,0,0,rs);
    for (int i = 0; i < 257; i++) step(0,1,1,8'(i),0,1,rs);
    step(0,0,0,0,0,1,rs);
    step(0,0,0,0,0,1,rs);
    chk("wrap_c2", int'(count2), 1);
    chk("wrap_c1", int'(count1), 0);

    // Random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0,199) == 0), 1'($urandom), 1'($urandom),
           8'($urandom), ($urandom_range(0,3) != 0),
           ($urandom_range(0,3) != 0), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
